// File: rtl/irq_ctrl_if.sv
// Register-access bus between a CPU-side master and the irq_ctrl register file.
interface irq_ctrl_if;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 32;

    logic              sel;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (output sel, output we, output addr, output wdata, input rdata);
    modport slave  (input sel, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: synchronizes sources, latches pending, claim/complete.
// Optional software trigger register at address 6 enabled by `define IRQ_CTRL_SWTRIG_EN.
module irq_ctrl #(
    parameter int unsigned NUM_SRC     = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_i,
    irq_ctrl_if.slave          bus,
    output logic               irq
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ID_W   = 5;

    localparam logic [2:0] A_PENDING  = 3'd0;
    localparam logic [2:0] A_ENABLE   = 3'd1;
    localparam logic [2:0] A_EDGE     = 3'd2;
    localparam logic [2:0] A_CLAIM    = 3'd3;
    localparam logic [2:0] A_COMPLETE = 3'd4;
    localparam logic [2:0] A_INSVC    = 3'd5;
    localparam logic [2:0] A_SWTRIG   = 3'd6;

    logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
    logic [NUM_SRC-1:0] s, prev_q, rise;
    logic [NUM_SRC-1:0] pending_q, enable_q, edge_q, insvc_q, avail;
    logic [NUM_SRC-1:0] pending_d, insvc_d;
    logic [NUM_SRC-1:0] claim_mask, cmpl_mask, w1c_mask, sw_set, set_mask, clr_mask;
    logic [ID_W-1:0]    claim_id, cmpl_id;
    logic               rd_c, wr_c, claim_c, cmpl_c;
    logic [DATA_W-1:0]  rd_val;
    logic               unused_wdata;

    assign s     = sync_q[SYNC_STAGES-1];
    assign rise  = s & ~prev_q;
    assign avail = pending_q & enable_q & ~insvc_q;

    assign rd_c = bus.sel & ~bus.we;
    assign wr_c = bus.sel &  bus.we;

    assign unused_wdata = ^bus.wdata[DATA_W-1:NUM_SRC];

    // Fixed priority: lowest index wins, id = index + 1, 0 = none
    always_comb begin
        claim_id = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (avail[i]) claim_id = ID_W'(i + 1);
        end
    end

    assign claim_c    = rd_c && (bus.addr == A_CLAIM) && (claim_id != '0);
    assign claim_mask = claim_c ? (NUM_SRC'(1) << (claim_id - ID_W'(1))) : '0;

    assign cmpl_id    = bus.wdata[ID_W-1:0];
    assign cmpl_c     = wr_c && (bus.addr == A_COMPLETE) && (cmpl_id != '0) &&
                        (32'(cmpl_id) <= NUM_SRC);
    assign cmpl_mask  = cmpl_c ? (NUM_SRC'(1) << (cmpl_id - ID_W'(1))) : '0;

    assign w1c_mask   = (wr_c && (bus.addr == A_PENDING)) ? bus.wdata[NUM_SRC-1:0] : '0;

`ifdef IRQ_CTRL_SWTRIG_EN
    assign sw_set = (wr_c && (bus.addr == A_SWTRIG)) ? bus.wdata[NUM_SRC-1:0] : '0;
`else
    assign sw_set = '0;
`endif

    // Edge bits: set beats clear; level bits simply track the synchronized input
    assign set_mask  = rise | sw_set;
    assign clr_mask  = w1c_mask | claim_mask;
    assign pending_d = (edge_q & ((pending_q & ~clr_mask) | set_mask)) | (~edge_q & s);
    assign insvc_d   = (insvc_q | claim_mask) & ~cmpl_mask;

    always_comb begin
        rd_val = '0;
        case (bus.addr)
            A_PENDING: rd_val = DATA_W'(pending_q);
            A_ENABLE:  rd_val = DATA_W'(enable_q);
            A_EDGE:    rd_val = DATA_W'(edge_q);
            A_CLAIM:   rd_val = DATA_W'(claim_id);
            A_INSVC:   rd_val = DATA_W'(insvc_q);
            default:   rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], src_i};
            prev_q <= s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            enable_q  <= '0;
            edge_q    <= '0;
            insvc_q   <= '0;
            bus.rdata <= '0;
            irq       <= 1'b0;
        end else begin
            pending_q <= pending_d;
            insvc_q   <= insvc_d;
            if (wr_c && (bus.addr == A_ENABLE)) enable_q <= bus.wdata[NUM_SRC-1:0];
            if (wr_c && (bus.addr == A_EDGE))   edge_q   <= bus.wdata[NUM_SRC-1:0];
            if (rd_c)                           bus.rdata <= rd_val;
            irq <= |avail;
        end
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed, table-driven bench for irq_ctrl: register map, latency, claim/complete, corner cases.
module tb_irq_ctrl;
    localparam int unsigned NUM_SRC = 8;
    localparam int unsigned NV      = 12;

    localparam logic [2:0] A_PENDING  = 3'd0;
    localparam logic [2:0] A_ENABLE   = 3'd1;
    localparam logic [2:0] A_EDGE     = 3'd2;
    localparam logic [2:0] A_CLAIM    = 3'd3;
    localparam logic [2:0] A_COMPLETE = 3'd4;
    localparam logic [2:0] A_INSVC    = 3'd5;
    localparam logic [2:0] A_SWTRIG   = 3'd6;

    typedef struct packed {
        logic        we;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NUM_SRC-1:0] src_i = '0;
    logic               irq;
    int                 n_pass = 0;
    int                 n_chk  = 0;
    vec_t               vecs [NV];

    irq_ctrl_if bus ();

    irq_ctrl #(.NUM_SRC(NUM_SRC), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .src_i (src_i),
        .bus   (bus.slave),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // All bus tasks start and end just after a falling edge
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
        @(negedge clk);
        bus.sel = 1'b0; bus.we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
        @(negedge clk);
        bus.sel = 1'b0;
        d = bus.rdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [NUM_SRC-1:0] m);
        src_i = m;
        @(negedge clk);
        src_i = '0;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] exp_p, exp_c;

        bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;

        vecs[0]  = '{1'b0, A_PENDING,  32'h0,        32'h0,  1'b0};
        vecs[1]  = '{1'b1, A_ENABLE,   32'h0000_01A5, 32'h0, 1'b0};
        vecs[2]  = '{1'b0, A_ENABLE,   32'h0,        32'hA5, 1'b0};
        vecs[3]  = '{1'b1, A_EDGE,     32'hFFFF_FF3C, 32'h0, 1'b0};
        vecs[4]  = '{1'b0, A_EDGE,     32'h0,        32'h3C, 1'b0};
        vecs[5]  = '{1'b0, A_CLAIM,    32'h0,        32'h0,  1'b0};
        vecs[6]  = '{1'b0, A_COMPLETE, 32'h0,        32'h0,  1'b0};
        vecs[7]  = '{1'b0, A_INSVC,    32'h0,        32'h0,  1'b0};
        vecs[8]  = '{1'b1, 3'd7,       32'h0000_FFFF, 32'h0, 1'b0};
        vecs[9]  = '{1'b0, 3'd7,       32'h0,        32'h0,  1'b0};
        vecs[10] = '{1'b1, A_CLAIM,    32'h0000_00FF, 32'h0, 1'b0};
        vecs[11] = '{1'b0, A_ENABLE,   32'h0,        32'hA5, 1'b0};

        // Reset state
        idle(2);
        check("reset rdata", bus.rdata, 32'h0);
        check("reset irq", 32'(irq), 32'h0);
        rst = 1'b0;
        idle(1);

        // Register map vectors with no sources active
        for (int i = 0; i < int'(NV); i++) begin
            if (vecs[i].we) begin
                wr(vecs[i].addr, vecs[i].wdata);
            end else begin
                rd(vecs[i].addr, d);
                check($sformatf("vec%0d rdata", i), d, vecs[i].exp_rdata);
            end
            check($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].exp_irq));
        end

        // Edge source 0: latency to irq, then claim
        wr(A_ENABLE, 32'h01);
        wr(A_EDGE, 32'h01);
        src_i = 8'h01;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            src_i = '0;
            check($sformatf("latency edge%0d irq", k), 32'(irq), (k == 3) ? 32'h1 : 32'h0);
        end
        rd(A_PENDING, d);  check("s1 pending", d, 32'h1);
        rd(A_CLAIM, d);    check("s1 claim", d, 32'h1);
        idle(1);           check("s1 irq after claim", 32'(irq), 32'h0);
        rd(A_INSVC, d);    check("s1 inservice", d, 32'h1);
        rd(A_PENDING, d);  check("s1 pending cleared", d, 32'h0);
        wr(A_COMPLETE, 32'd1);
        rd(A_INSVC, d);    check("s1 complete", d, 32'h0);

        // Two simultaneous edge sources, priority order
        wr(A_ENABLE, 32'hFF);
        wr(A_EDGE, 32'hFF);
        pulse(8'h24);
        idle(5);
        check("s2 irq", 32'(irq), 32'h1);
        rd(A_CLAIM, d);    check("s2 claim a", d, 32'd3);
        rd(A_CLAIM, d);    check("s2 claim b", d, 32'd6);
        rd(A_CLAIM, d);    check("s2 claim c", d, 32'd0);
        rd(A_INSVC, d);    check("s2 inservice", d, 32'h24);
        rd(A_PENDING, d);  check("s2 pending", d, 32'h0);
        check("s2 irq low", 32'(irq), 32'h0);
        wr(A_COMPLETE, 32'd3);
        rd(A_INSVC, d);    check("s2 complete 3", d, 32'h20);
        wr(A_COMPLETE, 32'd6);

        // Level source 1 held high across claim/complete
        wr(A_EDGE, 32'h00);
        wr(A_ENABLE, 32'h02);
        src_i = 8'h02;
        idle(5);
        check("s3 irq", 32'(irq), 32'h1);
        rd(A_CLAIM, d);    check("s3 claim", d, 32'd2);
        idle(1);           check("s3 irq masked", 32'(irq), 32'h0);
        idle(3);           check("s3 irq still masked", 32'(irq), 32'h0);
        wr(A_COMPLETE, 32'd2);
        check("s3 irq at complete edge", 32'(irq), 32'h0);
        idle(1);           check("s3 irq re-request", 32'(irq), 32'h1);
        src_i = '0;
        idle(1);
        rd(A_PENDING, d);  check("s3 pending edge1", d, 32'h02);
        rd(A_PENDING, d);  check("s3 pending edge2", d, 32'h02);
        rd(A_PENDING, d);  check("s3 pending edge3", d, 32'h00);

        // Edge source 0: set beats W1C in the same cycle
        wr(A_EDGE, 32'h01);
        wr(A_ENABLE, 32'h00);
        pulse(8'h01);
        idle(5);
        rd(A_PENDING, d);  check("s4 pending set", d, 32'h1);
        src_i = 8'h01;
        idle(2);
        wr(A_PENDING, 32'h1);
        src_i = '0;
        rd(A_PENDING, d);  check("s4 set wins", d, 32'h1);
        idle(3);
        wr(A_PENDING, 32'h1);
        rd(A_PENDING, d);  check("s4 w1c", d, 32'h0);
        pulse(8'h01);
        idle(5);
        wr(A_ENABLE, 32'h01);
        rd(A_CLAIM, d);    check("s4 claim", d, 32'd1);
        wr(A_COMPLETE, 32'd0);
        wr(A_COMPLETE, 32'd9);
        rd(A_INSVC, d);    check("s4 bad complete", d, 32'h1);
        wr(A_COMPLETE, 32'd1);
        rd(A_INSVC, d);    check("s4 good complete", d, 32'h0);

        // Disabled pending source, re-enable, then reset mid-access
        wr(A_ENABLE, 32'h00);
        wr(A_EDGE, 32'h08);
        pulse(8'h08);
        idle(5);
        check("s5 irq disabled", 32'(irq), 32'h0);
        rd(A_PENDING, d);  check("s5 pending", d, 32'h08);
        wr(A_ENABLE, 32'h08);
        check("s5 irq at enable edge", 32'(irq), 32'h0);
        idle(1);           check("s5 irq enabled", 32'(irq), 32'h1);
        bus.sel = 1'b1; bus.we = 1'b0; bus.addr = A_CLAIM;
        #2 rst = 1'b1;
        #1;
        check("s5 irq in reset", 32'(irq), 32'h0);
        check("s5 rdata in reset", bus.rdata, 32'h0);
        @(negedge clk);
        bus.sel = 1'b0;
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d);
            check($sformatf("s5 post-reset reg%0d", a), d, 32'h0);
        end
        check("s5 post-reset irq", 32'(irq), 32'h0);

        // Software trigger (only effective when the feature is built in)
`ifdef IRQ_CTRL_SWTRIG_EN
        exp_p = 32'h0F;
        exp_c = 32'd1;
`else
        exp_p = 32'h00;
        exp_c = 32'd0;
`endif
        wr(A_EDGE, 32'h0F);
        wr(A_ENABLE, 32'hFF);
        wr(A_SWTRIG, 32'hFF);
        rd(A_PENDING, d);  check("s6 pending", d, exp_p);
        rd(A_CLAIM, d);    check("s6 claim", d, exp_c);
        rd(A_SWTRIG, d);   check("s6 swtrig read", d, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
